divider: RTL and testbench

- Sequential unsigned restoring divider: WIDTH-bit dividend / WIDTH-bit divisor -> quotient and remainder.
- Inverse-operation companion to the team's radix-2 shift-add multiplier, with the same op_start/op_clear/op_done handshake.
- Sits beside the multiplier in the datapath; one quotient bit per clock.

---
 rtl/divider.sv | 147 ++++++++++++++
 tb/tb_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, op_start/op_clear/op_done handshake.
// Optional DIVIDER_DIVZERO_FLAG_EN adds a sticky div_by_zero output flag.
module divider #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             op_done,
    output logic [WIDTH-1:0] quotient,
`ifdef DIVIDER_DIVZERO_FLAG_EN
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
`else
    output logic [WIDTH-1:0] remainder
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH:0]     diff_s;
    logic               ge_s;

    // Next-state, datapath step and output load, op_clear taking priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        q_d     = q_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        // Compare/subtract one bit wider than the operands so a shifted-in MSB cannot overflow.
        trial_s = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff_s  = trial_s - {1'b0, dvs_q};
        ge_s    = (trial_s >= {1'b0, dvs_q});

        if (op_clear) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            dvs_d   = {WIDTH{1'b0}};
            p_d     = {(WIDTH+1){1'b0}};
            q_d     = {WIDTH{1'b0}};
            quo_d   = {WIDTH{1'b0}};
            rem_d   = {WIDTH{1'b0}};
            done_d  = 1'b0;
            dbz_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_start) begin
                        state_d = S_EXEC;
                        cnt_d   = {CNT_W{1'b0}};
                        dvs_d   = divisor;
                        p_d     = {(WIDTH+1){1'b0}};
                        q_d     = dividend;
                        quo_d   = {WIDTH{1'b0}};
                        rem_d   = {WIDTH{1'b0}};
                        done_d  = 1'b0;
                        dbz_d   = (divisor == {WIDTH{1'b0}});
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_EXEC: begin
                    p_d = ge_s ? diff_s : trial_s;
                    q_d = {q_q[WIDTH-2:0], ge_s};
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    // Outputs are registered off the final Q/P, so op_done lands one edge into DONE.
                    quo_d  = q_q;
                    rem_d  = p_q[WIDTH-1:0];
                    done_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            p_q     <= {(WIDTH+1){1'b0}};
            q_q     <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            q_q     <= q_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign op_done   = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

`ifdef DIVIDER_DIVZERO_FLAG_EN
    assign div_by_zero = dbz_q;
`else
    logic unused_dbz_s;
    assign unused_dbz_s = dbz_q;
`endif

endmodule

// File: tb/tb_divider.sv
// Directed, table-driven bench for divider: latency, results, hold, clear/reset/ignore corner cases.
module tb_divider;

    logic        clk;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        op_done;
    logic [63:0] quotient;
    logic [63:0] remainder;
`ifdef DIVIDER_DIVZERO_FLAG_EN
    logic        div_by_zero;
`endif

    int n_vec;
    int n_err;

    divider #(.WIDTH(64), .CNT_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_start   (op_start),
        .op_clear   (op_clear),
        .dividend   (dividend),
        .divisor    (divisor),
        .op_done    (op_done),
        .quotient   (quotient),
`ifdef DIVIDER_DIVZERO_FLAG_EN
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
`else
        .remainder  (remainder)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_q;
        logic [63:0] exp_r;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
    endtask

    // Counts edges from the accepting edge until op_done; returns 200 on timeout.
    task automatic wait_done(output int edges);
        edges = 0;
        while (op_done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Runs N edges and reports whether op_done was ever seen high.
    task automatic watch_idle(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (op_done !== 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        logic seen;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{64'd100, 64'd7, 64'd14, 64'd2};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[2]  = '{64'd0, 64'd5, 64'd0, 64'd0};
        vecs[3]  = '{64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd12345};
        vecs[4]  = '{64'd1000, 64'd3, 64'd333, 64'd1};
        vecs[5]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        vecs[7]  = '{64'd5, 64'd10, 64'd0, 64'd5};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[9]  = '{64'h0000_0000_DEAD_BEEF, 64'd16, 64'h0000_0000_0DEA_DBEE, 64'd15};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF};

        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = 64'd0;
        divisor  = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_op_done", {63'd0, op_done}, 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_start(vecs[i].a, vecs[i].b);
`ifdef DIVIDER_DIVZERO_FLAG_EN
            check($sformatf("v%0d_dbz_exec", i), {63'd0, div_by_zero}, {63'd0, vecs[i].b == 64'd0});
`endif
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd65);
            check($sformatf("v%0d_quotient", i), quotient, vecs[i].exp_q);
            check($sformatf("v%0d_remainder", i), remainder, vecs[i].exp_r);
`ifdef DIVIDER_DIVZERO_FLAG_EN
            check($sformatf("v%0d_dbz_done", i), {63'd0, div_by_zero}, {63'd0, vecs[i].b == 64'd0});
`endif
            do_clear();
            check($sformatf("v%0d_clr_done", i), {63'd0, op_done}, 64'd0);
            check($sformatf("v%0d_clr_quotient", i), quotient, 64'd0);
`ifdef DIVIDER_DIVZERO_FLAG_EN
            check($sformatf("v%0d_clr_dbz", i), {63'd0, div_by_zero}, 64'd0);
`endif
        end

        // Results hold in DONE; a start pulse there is ignored.
        do_start(64'd100, 64'd7);
        wait_done(lat);
        do_start(64'd9, 64'd2);
        repeat (4) @(posedge clk);
        #1;
        check("hold_done", {63'd0, op_done}, 64'd1);
        check("hold_quotient", quotient, 64'd14);
        check("hold_remainder", remainder, 64'd2);
        do_clear();
        check("hold_clr_remainder", remainder, 64'd0);

        // op_clear mid-EXEC aborts; a fresh start afterwards is normal.
        do_start(64'd1000, 64'd3);
        repeat (19) @(posedge clk);
        do_clear();
        watch_idle(80, seen);
        check("abort_no_done", {63'd0, seen}, 64'd0);
        do_start(64'd1000, 64'd3);
        wait_done(lat);
        check("abort_restart_latency", 64'(lat), 64'd65);
        check("abort_restart_quotient", quotient, 64'd333);
        check("abort_restart_remainder", remainder, 64'd1);
        do_clear();

        // Async reset mid-EXEC.
        do_start(64'd100, 64'd7);
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_done", {63'd0, op_done}, 64'd0);
        check("rst_mid_quotient", quotient, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        watch_idle(80, seen);
        check("rst_mid_no_done", {63'd0, seen}, 64'd0);
        do_start(64'd100, 64'd7);
        wait_done(lat);
        check("rst_restart_latency", 64'(lat), 64'd65);
        check("rst_restart_quotient", quotient, 64'd14);
        check("rst_restart_remainder", remainder, 64'd2);
        do_clear();

        // Operand changes and start re-pulse during EXEC are ignored.
        do_start(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (10) @(posedge clk);
        do_start(64'd100, 64'd7);
        dividend = 64'd55;
        divisor  = 64'd4;
        wait_done(lat);
        check("exec_ign_done", {63'd0, op_done}, 64'd1);
        check("exec_ign_quotient", quotient, 64'd0);
        check("exec_ign_remainder", remainder, 64'h8000_0000_0000_0000);
        do_clear();

        // Clear and start together in IDLE: clear wins.
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 64'd7;
        op_start = 1'b1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_clear = 1'b0;
        watch_idle(80, seen);
        check("clr_start_no_done", {63'd0, seen}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
